// File: rtl/rvc_asap_core.sv
// rvc_asap_core: single-cycle RV32I core with private byte-wide instruction and data memories.
// Fetch, decode, execute, memory access and writeback all complete within one clock.
module rvc_asap_core #(
  parameter int unsigned I_MEM_MSB = 1023,
  parameter int unsigned D_MEM_MSB = 2047
) (
  input logic Clock,
  input logic Rst
);

  localparam int unsigned IW = $clog2(I_MEM_MSB + 1);
  localparam int unsigned DW = $clog2(D_MEM_MSB + 1);

  localparam logic [31:0] Ebreak   = 32'h0010_0073;
  localparam logic [6:0]  OpLui    = 7'b0110111;
  localparam logic [6:0]  OpAuipc  = 7'b0010111;
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpJalr   = 7'b1100111;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpImm    = 7'b0010011;
  localparam logic [6:0]  OpReg    = 7'b0110011;
  localparam logic [6:0]  OpSystem = 7'b1110011;

  logic [7:0]  IMem [I_MEM_MSB:0];
  logic [7:0]  DMem [D_MEM_MSB:I_MEM_MSB+1];
  logic [31:0] Instruction;

  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] regs [32];
  logic        halt;

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  logic        br_taken;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        is_ebreak;
  logic [3:0]  st_be;
  logic [31:0] st_addr;
  logic [31:0] st_a [4];
  logic [31:0] ld_addr;
  logic [31:0] ld_a [4];
  logic [7:0]  ld_b [4];
  logic        ld_ok;
  logic [31:0] ld_data;

  function automatic logic in_dmem(input logic [31:0] a);
    return (a >= 32'(I_MEM_MSB + 1)) && (a <= 32'(D_MEM_MSB));
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'd0:    r = alt ? (a - b) : (a + b);
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = {31'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  // Fetch: a word that would run past the top of IMem reads as zero (a NOP).
  always_comb begin
    Instruction = '0;
    if (({1'b0, pc} + 33'd3) <= 33'(I_MEM_MSB)) begin
      Instruction = {IMem[pc[IW-1:0] + IW'(3)], IMem[pc[IW-1:0] + IW'(2)],
                     IMem[pc[IW-1:0] + IW'(1)], IMem[pc[IW-1:0]]};
    end
  end

  assign opcode  = Instruction[6:0];
  assign rd      = Instruction[11:7];
  assign f3      = Instruction[14:12];
  assign rs1     = Instruction[19:15];
  assign rs2     = Instruction[24:20];
  assign f7      = Instruction[31:25];
  assign imm_i   = {{20{Instruction[31]}}, Instruction[31:20]};
  assign imm_s   = {{20{Instruction[31]}}, Instruction[31:25], Instruction[11:7]};
  assign imm_b   = {{19{Instruction[31]}}, Instruction[31], Instruction[7],
                    Instruction[30:25], Instruction[11:8], 1'b0};
  assign imm_u   = {Instruction[31:12], 12'd0};
  assign imm_j   = {{11{Instruction[31]}}, Instruction[31], Instruction[19:12],
                    Instruction[20], Instruction[30:21], 1'b0};
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  always_comb begin
    case (f3)
      3'b000:  br_taken = rs1_val == rs2_val;
      3'b001:  br_taken = rs1_val != rs2_val;
      3'b100:  br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'b101:  br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'b110:  br_taken = rs1_val < rs2_val;
      3'b111:  br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // Loads: any byte of the access outside DMem makes the whole result zero.
  always_comb begin
    ld_addr = rs1_val + imm_i;
    st_addr = rs1_val + imm_s;
    for (int k = 0; k < 4; k++) begin
      ld_a[k] = ld_addr + 32'(k);
      st_a[k] = st_addr + 32'(k);
      ld_b[k] = in_dmem(ld_a[k]) ? DMem[ld_a[k][DW-1:0]] : 8'h00;
    end
    case (f3[1:0])
      2'b00:   ld_ok = in_dmem(ld_a[0]);
      2'b01:   ld_ok = in_dmem(ld_a[0]) && in_dmem(ld_a[1]);
      default: ld_ok = in_dmem(ld_a[0]) && in_dmem(ld_a[1]) && in_dmem(ld_a[2]) &&
                       in_dmem(ld_a[3]);
    endcase
    ld_data = '0;
    if (ld_ok) begin
      case (f3)
        3'b000:  ld_data = {{24{ld_b[0][7]}}, ld_b[0]};
        3'b001:  ld_data = {{16{ld_b[1][7]}}, ld_b[1], ld_b[0]};
        3'b100:  ld_data = {24'd0, ld_b[0]};
        3'b101:  ld_data = {16'd0, ld_b[1], ld_b[0]};
        default: ld_data = {ld_b[3], ld_b[2], ld_b[1], ld_b[0]};
      endcase
    end
  end

  always_comb begin
    pc_next   = pc + 32'd4;
    wr_en     = 1'b0;
    wr_data   = '0;
    st_be     = 4'b0000;
    is_ebreak = 1'b0;
    case (opcode)
      OpLui: begin
        wr_en   = 1'b1;
        wr_data = imm_u;
      end
      OpAuipc: begin
        wr_en   = 1'b1;
        wr_data = pc + imm_u;
      end
      OpJal: begin
        wr_en   = 1'b1;
        wr_data = pc + 32'd4;
        pc_next = pc + imm_j;
      end
      OpJalr: begin
        if (f3 == 3'b000) begin
          wr_en   = 1'b1;
          wr_data = pc + 32'd4;
          pc_next = (rs1_val + imm_i) & ~32'd1;
        end
      end
      OpBranch: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      OpLoad: begin
        if (f3 != 3'b011 && f3 < 3'b110) begin
          wr_en   = 1'b1;
          wr_data = ld_data;
        end
      end
      OpStore: begin
        case (f3)
          3'b000:  st_be = 4'b0001;
          3'b001:  st_be = 4'b0011;
          3'b010:  st_be = 4'b1111;
          default: st_be = 4'b0000;
        endcase
      end
      OpImm: begin
        // Shift-immediates with a malformed upper field fall through as NOPs.
        if (!((f3 == 3'b001 && f7 != 7'h00) ||
              (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20))) begin
          wr_en   = 1'b1;
          wr_data = alu(f3, (f3 == 3'b101) && f7[5], rs1_val, imm_i);
        end
      end
      OpReg: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))) begin
          wr_en   = 1'b1;
          wr_data = alu(f3, f7[5], rs1_val, rs2_val);
        end
      end
      OpSystem: begin
        if (Instruction == Ebreak) begin
          is_ebreak = 1'b1;
          pc_next   = pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      pc   <= '0;
      halt <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (!halt) begin
      pc <= pc_next;
      if (is_ebreak) halt <= 1'b1;
      if (wr_en && rd != 5'd0) regs[rd] <= wr_data;
    end
  end

  // DMem is not reset; each store byte lands only if its own address falls inside DMem.
  always_ff @(posedge Clock) begin
    if (Rst && !halt) begin
      for (int k = 0; k < 4; k++) begin
        if (st_be[k] && in_dmem(st_a[k])) DMem[st_a[k][DW-1:0]] <= rs2_val[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rvc_asap_core.sv
// tb_rvc_asap_core: directed vector table plus random programs run in lockstep with an
// instruction-level reference model of the RV32I subset.
module tb_rvc_asap_core;

  localparam int unsigned IMSB = 1023;
  // DMem is enlarged so the 0x1000 scratch area and a 0x2000 top edge are both reachable.
  localparam int unsigned DMSB = 8191;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  localparam int KReg = 0, KPc = 1, KIns = 2, KDmem = 3, KHalt = 4, KImem = 5;

  typedef struct {
    int          test;
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rvc_asap_core #(.I_MEM_MSB(IMSB), .D_MEM_MSB(DMSB)) dut (.Clock(clk), .Rst(rst_n));

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_imem [0:IMSB];
  logic [7:0]  m_dmem [0:DMSB];
  logic [31:0] m_x [32];
  logic [31:0] m_pc;
  bit          m_halt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- instruction encoders ----
  function automatic logic [31:0] enc_i(int op, int rd, int f3, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(int f3, int rs1, int rs2, int imm);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(int f3, int rs1, int rs2, int off);
    logic [12:0] m;
    m = 13'(off);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(int op, int rd, int imm20);
    return {20'(imm20), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_j(int rd, int off);
    logic [20:0] m;
    m = 21'(off);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] addi(int rd, int rs1, int imm);
    return enc_i(7'h13, rd, 0, rs1, imm);
  endfunction

  // ---- reference model ----
  function automatic bit m_in(input logic [31:0] a);
    return a >= 32'(IMSB + 1) && a <= 32'(DMSB);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < n; k++) if (!m_in(a + 32'(k))) return 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(m_dmem[a + 32'(k)]) << (8 * k));
    return v;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] v, input int n);
    logic [31:0] w;
    w = v;
    for (int k = 0; k < n; k++) if (m_in(a + 32'(k))) m_dmem[a + 32'(k)] = w[8*k +: 8];
  endtask

  function automatic logic [31:0] m_fetch();
    logic [32:0] e;
    e = {1'b0, m_pc} + 33'd3;
    if (e > 33'(IMSB)) return 32'd0;
    return {m_imem[m_pc + 3], m_imem[m_pc + 2], m_imem[m_pc + 1], m_imem[m_pc]};
  endfunction

  task automatic m_step();
    logic [31:0] ins, a, b, imm_i, imm_s, imm_b, imm_j, res, npc;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  sh;
    bit          wr, take;
    if (m_halt) return;
    ins = m_fetch();
    if (ins == EBREAK) begin
      m_halt = 1;
      return;
    end
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    a = m_x[ins[19:15]]; b = m_x[ins[24:20]];
    imm_i = {{20{ins[31]}}, ins[31:20]};
    imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    sh = imm_i[4:0];
    npc = m_pc + 4; wr = 0; res = 0; take = 0;
    case (op)
      7'h37: begin wr = 1; res = {ins[31:12], 12'd0}; end
      7'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'd0}; end
      7'h6F: begin wr = 1; res = m_pc + 4; npc = m_pc + imm_j; end
      7'h67: if (f3 == 0) begin wr = 1; res = m_pc + 4; npc = (a + imm_i) & ~32'd1; end
      7'h63: begin
        case (f3)
          0: take = a == b;
          1: take = a != b;
          4: take = $signed(a) < $signed(b);
          5: take = $signed(a) >= $signed(b);
          6: take = a < b;
          7: take = a >= b;
          default: take = 0;
        endcase
        if (take) npc = m_pc + imm_b;
      end
      7'h03: begin
        wr = 1;
        case (f3)
          0: begin res = m_load(a + imm_i, 1); res = {{24{res[7]}}, res[7:0]}; end
          1: begin res = m_load(a + imm_i, 2); res = {{16{res[15]}}, res[15:0]}; end
          2: res = m_load(a + imm_i, 4);
          4: res = m_load(a + imm_i, 1);
          5: res = m_load(a + imm_i, 2);
          default: wr = 0;
        endcase
      end
      7'h23: if (f3 < 3) m_store(a + imm_s, b, 1 << f3);
      7'h13: begin
        wr = 1;
        case (f3)
          0: res = a + imm_i;
          2: res = ($signed(a) < $signed(imm_i)) ? 1 : 0;
          3: res = (a < imm_i) ? 1 : 0;
          4: res = a ^ imm_i;
          6: res = a | imm_i;
          7: res = a & imm_i;
          1: if (f7 == 0) res = a << sh; else wr = 0;
          default: if (f7 == 0) res = a >> sh;
                   else if (f7 == 7'h20) res = 32'($signed(a) >>> sh);
                   else wr = 0;
        endcase
      end
      7'h33: begin
        wr = 1;
        if (f7 == 0) begin
          case (f3)
            0: res = a + b;
            1: res = a << b[4:0];
            2: res = ($signed(a) < $signed(b)) ? 1 : 0;
            3: res = (a < b) ? 1 : 0;
            4: res = a ^ b;
            5: res = a >> b[4:0];
            6: res = a | b;
            default: res = a & b;
          endcase
        end else if (f7 == 7'h20 && f3 == 0) res = a - b;
        else if (f7 == 7'h20 && f3 == 5) res = 32'($signed(a) >>> b[4:0]);
        else wr = 0;
      end
      default: ;
    endcase
    if (wr && ins[11:7] != 0) m_x[ins[11:7]] = res;
    m_pc = npc;
  endtask

  // ---- program loading and reset ----
  task automatic start(input logic [31:0] prog[$], input bit rnd);
    logic [31:0] w;
    logic [7:0]  v;
    @(negedge clk);
    rst_n = 1'b0;
    for (int a = 0; a <= int'(IMSB); a++) begin
      dut.IMem[a] = 8'h00;
      m_imem[a] = 8'h00;
    end
    foreach (prog[i]) begin
      w = prog[i];
      for (int k = 0; k < 4; k++) begin
        dut.IMem[4*i + k] = w[8*k +: 8];
        m_imem[4*i + k] = w[8*k +: 8];
      end
    end
    for (int a = int'(IMSB) + 1; a <= int'(DMSB); a++) begin
      v = rnd ? 8'($urandom) : 8'h00;
      dut.DMem[a] = v;
      m_dmem[a] = v;
    end
    m_pc = 0; m_halt = 0;
    for (int r = 0; r < 32; r++) m_x[r] = 0;
    #40;
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      KReg:  return dut.regs[idx];
      KPc:   return dut.pc;
      KIns:  return dut.Instruction;
      KDmem: return {24'd0, dut.DMem[idx]};
      KHalt: return {31'd0, dut.halt};
      default: return {24'd0, dut.IMem[idx]};
    endcase
  endfunction

  task automatic run_random(input int n, input int tag);
    logic [31:0] prog[$];
    logic [31:0] ins;
    int rd, rs1, rs2, f3, base, off, sel, mism;
    prog = {enc_u(7'h37, 10, 1), enc_u(7'h37, 11, 2)};
    for (int i = 0; i < n; i++) begin
      rd = $urandom_range(1, 29);
      if (rd >= 10) rd += 2;
      rs1 = $urandom_range(0, 31); rs2 = $urandom_range(0, 31); f3 = $urandom_range(0, 7);
      sel = $urandom_range(0, 2);
      base = (sel == 0) ? 10 : (sel == 1) ? 11 : 0;
      off = (sel == 0) ? int'($urandom_range(0, 255)) - 128 :
            (sel == 1) ? int'($urandom_range(0, 8)) - 6 : int'($urandom_range(0, 16));
      case ($urandom_range(0, 15))
        0, 1, 2, 3: begin
          if (f3 == 1) ins = enc_i(7'h13, rd, 1, rs1, $urandom_range(0, 31));
          else if (f3 == 5)
            ins = enc_i(7'h13, rd, 5, rs1, ($urandom_range(0, 1) << 10) | $urandom_range(0, 31));
          else ins = enc_i(7'h13, rd, f3, rs1, $urandom);
        end
        4, 5, 6: ins = enc_r(((f3 == 0 || f3 == 5) && $urandom_range(0, 1) == 1) ? 7'h20 : 0,
                             rs2, rs1, f3, rd);
        7: ins = enc_u($urandom_range(0, 1) ? 7'h37 : 7'h17, rd, $urandom);
        8, 9: begin
          f3 = $urandom_range(0, 4);
          if (f3 == 3) f3 = 5;
          ins = enc_i(7'h03, rd, f3, base, off);
        end
        10, 11: ins = enc_s($urandom_range(0, 2), base, rs2, off);
        12, 13: begin
          if (f3 == 2 || f3 == 3) f3 += 4;
          ins = enc_b(f3, rs1, rs2, $urandom_range(0, 1) ? 8 : 12);
        end
        14: ins = enc_j(rd, $urandom_range(0, 1) ? 8 : 12);
        default: begin
          case ($urandom_range(0, 3))
            0: ins = 32'hFFFF_FFFF;
            1: ins = 32'h0000_000F;
            2: ins = 32'h0000_0073;
            default: ins = 32'h0;
          endcase
        end
      endcase
      prog.push_back(ins);
    end
    repeat (3) prog.push_back(EBREAK);
    start(prog, 1'b1);
    for (int c = 0; c < 300 && !m_halt; c++) begin
      @(posedge clk);
      m_step();
      #1;
      check($sformatf("rnd%0d_pc@%0d", tag, c), dut.pc, m_pc);
    end
    check($sformatf("rnd%0d_halt", tag), {31'd0, dut.halt}, {31'd0, m_halt});
    for (int r = 1; r < 32; r++) check($sformatf("rnd%0d_x%0d", tag, r), dut.regs[r], m_x[r]);
    mism = 0;
    for (int a = int'(IMSB) + 1; a <= int'(DMSB); a++) if (dut.DMem[a] !== m_dmem[a]) mism++;
    check($sformatf("rnd%0d_dmem_mismatch_bytes", tag), 32'(mism), 32'd0);
  endtask

  initial begin
    chk_t        tbl[$];
    logic [31:0] progs[7][$];
    int          cyc[7];

    progs[1] = {addi(1, 0, 5)};
    progs[2] = {addi(1, 0, -1), enc_i(7'h13, 2, 5, 1, 28), enc_i(7'h13, 3, 5, 1, 12'h41C),
                enc_r(0, 1, 0, 3, 4), EBREAK};
    progs[3] = {enc_u(7'h37, 5, 1), addi(6, 0, 12'h080), enc_s(0, 5, 6, 0),
                enc_i(7'h03, 7, 0, 5, 0), enc_i(7'h03, 8, 4, 5, 0), addi(9, 0, 3),
                enc_s(2, 0, 6, 0), enc_i(7'h03, 9, 2, 0, 0), enc_u(7'h37, 12, 2),
                addi(16, 0, -1), enc_s(2, 12, 16, -2), enc_i(7'h03, 13, 2, 12, -2),
                enc_i(7'h03, 14, 5, 12, -2), addi(15, 0, 5), enc_i(7'h03, 15, 4, 12, 0), EBREAK};
    progs[4] = {addi(2, 0, 1), enc_b(0, 0, 0, 8), addi(2, 0, 99), enc_j(1, 12), addi(3, 0, 1),
                enc_j(0, 16), addi(4, 0, 7), enc_i(7'h67, 0, 0, 1, 0), addi(4, 0, 55),
                addi(5, 0, -1), enc_b(6, 2, 5, 8), addi(6, 0, 9), EBREAK};
    progs[5] = {addi(0, 0, 7), 32'hFFFF_FFFF, addi(1, 0, 2), EBREAK};
    progs[6] = {addi(1, 1, 1), addi(1, 1, 1), addi(1, 1, 1), addi(1, 1, 1), EBREAK};
    cyc = '{0, 1, 40, 40, 40, 40, 40};

    tbl = '{
      '{1, "t1_x1", KReg, 1, 32'd5},            '{1, "t1_pc", KPc, 0, 32'd4},
      '{2, "t2_srli", KReg, 2, 32'h0000_000F},  '{2, "t2_srai", KReg, 3, 32'hFFFF_FFFF},
      '{2, "t2_sltu", KReg, 4, 32'd1},          '{2, "t2_pc", KPc, 0, 32'h10},
      '{3, "t3_lb", KReg, 7, 32'hFFFF_FF80},    '{3, "t3_lbu", KReg, 8, 32'h80},
      '{3, "t3_lw_imem", KReg, 9, 32'd0},       '{3, "t3_imem_kept", KImem, 0, 32'hB7},
      '{3, "t3_dmem1000", KDmem, 'h1000, 32'h80},
      '{3, "t3_dmem1ffe", KDmem, 'h1FFE, 32'hFF}, '{3, "t3_dmem1fff", KDmem, 'h1FFF, 32'hFF},
      '{3, "t3_lw_straddle", KReg, 13, 32'd0},  '{3, "t3_lhu_top", KReg, 14, 32'h0000_FFFF},
      '{3, "t3_lbu_above", KReg, 15, 32'd0},
      '{4, "t4_x1_link", KReg, 1, 32'h10},      '{4, "t4_beq_skip", KReg, 2, 32'd1},
      '{4, "t4_return", KReg, 3, 32'd1},        '{4, "t4_jal_skip", KReg, 4, 32'd7},
      '{4, "t4_bltu_skip", KReg, 6, 32'd0},     '{4, "t4_pc", KPc, 0, 32'h30},
      '{5, "t5_x0", KReg, 0, 32'd0},            '{5, "t5_x1", KReg, 1, 32'd2},
      '{5, "t5_pc", KPc, 0, 32'h0C},            '{5, "t5_halt", KHalt, 0, 32'd1},
      '{6, "t6_pc", KPc, 0, 32'h10},            '{6, "t6_ins", KIns, 0, EBREAK},
      '{6, "t6_halt", KHalt, 0, 32'd1},         '{6, "t6_x1", KReg, 1, 32'd4}
    };

    for (int t = 1; t <= 6; t++) begin
      start(progs[t], 1'b0);
      repeat (cyc[t]) @(posedge clk);
      #1;
      foreach (tbl[i]) if (tbl[i].test == t) check(tbl[i].name, actual(tbl[i].kind, tbl[i].idx),
                                                   tbl[i].exp);
    end

    // Halted core stays frozen; an asynchronous reset mid-cycle restarts it from Pc=0.
    repeat (5) @(posedge clk);
    #1;
    check("t6_pc_frozen", dut.pc, 32'h10);
    check("t6_x1_frozen", dut.regs[1], 32'd4);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_pc", dut.pc, 32'd0);
    check("rst_async_halt", {31'd0, dut.halt}, 32'd0);
    check("rst_async_x1", dut.regs[1], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_pc", dut.pc, 32'd4);
    check("restart_x1", dut.regs[1], 32'd1);

    for (int r = 0; r < 6; r++) run_random(40, r);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
